cache_arbiter: RTL and testbench

Arbitrates line-sized misses from the instruction cache and the data cache onto the single physical-memory port. It sits directly downstream of the pipeline's instruction and data caches, which are themselves fed by the datapath's `inst_*` and `data_*` ports. Only one memory transaction is in flight at a time. Each grant latches the requester's address and write data, holds the memory strobes until `pmem_resp`, then returns a registered one-cycle response to the winner.

---
 rtl/cache_arbiter_if.sv | 43 ++++
 rtl/cache_arbiter.sv | 137 +++++++++++++
 tb/tb_cache_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: icache, dcache and physical-memory signals of the
// miss arbiter; slave is the arbiter's view, master the environment's.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: one-in-flight I$/D$ line-miss arbiter onto a single pmem port.
// Define CACHE_ARB_RR_EN for round-robin ties; otherwise the dcache wins.
module cache_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP
  } state_e;

  state_e r_state, w_next;

  logic                  w_d_req;
  logic                  w_d_wins;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_unused;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic                  r_write;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_i_resp;
  logic                  r_d_resp;

  assign w_d_req  = bus.d_read | bus.d_write;
  assign w_busy   = (r_state == I_BUSY) ||
                    (r_state == D_BUSY);
  assign w_done   = w_busy & bus.pmem_resp;
  assign w_unused = ^{bus.i_addr[OFFSET_BITS-1:0],
                      bus.d_addr[OFFSET_BITS-1:0]};

`ifdef CACHE_ARB_RR_EN
  // r_ptr = 1 prefers the dcache on the next tie
  logic r_ptr;
  assign w_d_wins = r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (w_gnt_i) begin
      r_ptr <= 1'b1;
    end else if (w_gnt_d) begin
      r_ptr <= 1'b0;
    end
  end
`else
  assign w_d_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_d_req && (w_d_wins || !bus.i_read)) begin
          w_gnt_d = 1'b1;
          w_next  = D_BUSY;
        end else if (bus.i_read) begin
          w_gnt_i = 1'b1;
          w_next  = I_BUSY;
        end
      end
      I_BUSY:  if (bus.pmem_resp) w_next = I_RESP;
      D_BUSY:  if (bus.pmem_resp) w_next = D_RESP;
      I_RESP:  w_next = IDLE;
      D_RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_req_addr = w_gnt_d ? bus.d_addr : bus.i_addr;

  // strobes lag the grant by one edge and drop on the completing edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_gnt_i || w_gnt_d) begin
        r_addr  <= {w_req_addr[ADDR_WIDTH-1:OFFSET_BITS],
                    {OFFSET_BITS{1'b0}}};
        r_write <= w_gnt_d & bus.d_write;
      end
      if (w_gnt_d && bus.d_write) begin
        r_wdata <= bus.d_wdata;
      end
      r_rd     <= w_busy & ~bus.pmem_resp & ~r_write;
      r_wr     <= w_busy & ~bus.pmem_resp & r_write;
      r_i_resp <= w_done & (r_state == I_BUSY);
      r_d_resp <= w_done & (r_state == D_BUSY);
      if (w_done && r_state == I_BUSY) begin
        r_i_rdata <= bus.pmem_rdata;
      end
      if (w_done && r_state == D_BUSY) begin
        r_d_rdata <= bus.pmem_rdata;
      end
    end
  end

  assign bus.pmem_read    = r_rd;
  assign bus.pmem_write   = r_wr;
  assign bus.pmem_address = r_addr;
  assign bus.pmem_wdata   = r_wdata;
  assign bus.i_resp       = r_i_resp;
  assign bus.d_resp       = r_d_resp;
  assign bus.i_rdata      = r_i_rdata;
  assign bus.d_rdata      = r_d_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: vector table of single transactions plus directed
// sequences for ties, starvation, held requests and mid-transaction reset.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  cache_arbiter #(
    .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic          ir;
    logic          dr;
    logic          dw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] wd;
    logic [LW-1:0] rd;
    int            lat;
    logic          exp_i;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // memory model: answers after mem_lat strobe cycles, logs each txn
  int            mem_lat    = 4;
  logic [LW-1:0] rd_pat     = '0;
  bit            force_resp = 1'b0;
  int            cnt        = 0;
  int            sc         = 0;
  int            n_log      = 0;
  int            both_bad   = 0;
  logic [AW-1:0] log_addr [64];
  logic          log_wr   [64];
  logic [LW-1:0] log_wd   [64];
  int            log_sc   [64];

  always @(negedge clk) begin
    bus.pmem_rdata = rd_pat;
    if (!reset) begin
      cnt = 0;
      sc  = 0;
      bus.pmem_resp = 1'b0;
    end else begin
      if (bus.pmem_read || bus.pmem_write) sc++;
      if (bus.pmem_read && bus.pmem_write) both_bad++;
      if (force_resp) begin
        bus.pmem_resp = 1'b1;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt == 1) begin
          log_addr[n_log % 64] = bus.pmem_address;
          log_wr[n_log % 64]   = bus.pmem_write;
          log_wd[n_log % 64]   = bus.pmem_wdata;
        end
        if (cnt >= mem_lat) begin
          bus.pmem_resp = 1'b1;
          log_sc[n_log % 64] = sc;
          sc  = 0;
          cnt = 0;
          n_log++;
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_resp(input string nm, output logic gi,
                           output logic gd, output int dt);
    int t0;
    t0 = cyc;
    gi = 1'b0;
    gd = 1'b0;
    dt = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.i_resp || bus.d_resp) begin
        gi = bus.i_resp;
        gd = bus.d_resp;
        dt = cyc - t0;
        break;
      end
      nxt();
    end
    if (dt < 0) begin
      n_chk++;
      $display("FAIL %s timeout: got no response, expected one within 40 cycles", nm);
    end
  endtask

  task automatic drop_all();
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  vec_t          vt [5];
  logic [LW-1:0] inc;
  logic [LW-1:0] ei_rd;
  logic [LW-1:0] ed_rd;
  logic          gi, gd;
  int            dt, n0, served;

  initial begin
    for (int b = 0; b < 32; b++) inc[b*8 +: 8] = b[7:0];
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h6000_0047, 32'h0, '0,
              {32{8'hA5}}, 4, 1'b1, 1'b0, 32'h6000_0040};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_567F, inc,
              {32{8'h3C}}, 3, 1'b0, 1'b1, 32'h1234_5660};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, '0,
              {32{8'h5A}}, 1, 1'b0, 1'b0, 32'hFFFF_FFE0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_001F, 32'h0, '0,
              {16{16'hBEEF}}, 2, 1'b1, 1'b0, 32'h0000_0000};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0027, ~inc,
              {8{32'h0123_4567}}, 5, 1'b0, 1'b1, 32'h8000_0020};

    reset       = 1'b0;
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    ei_rd = '0;
    ed_rd = '0;
    repeat (3) nxt();
    chk("rst pmem_read", bus.pmem_read, 1'b0);
    chk("rst pmem_write", bus.pmem_write, 1'b0);
    chk("rst resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst pmem_address", bus.pmem_address, 0);
    chk("rst pmem_wdata", bus.pmem_wdata, 0);
    chk("rst rdata", bus.i_rdata | bus.d_rdata, 0);
    reset = 1'b1;
    nxt();
    nxt();
    chk("idle strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);

    for (int v = 0; v < 5; v++) begin
      n0 = n_log;
      mem_lat     = vt[v].lat;
      rd_pat      = vt[v].rd;
      bus.i_read  = vt[v].ir;
      bus.i_addr  = vt[v].ia;
      bus.d_read  = vt[v].dr;
      bus.d_write = vt[v].dw;
      bus.d_addr  = vt[v].da;
      bus.d_wdata = vt[v].wd;
      wait_resp($sformatf("v%0d", v), gi, gd, dt);
      chk($sformatf("v%0d resp side", v), {gi, gd},
          vt[v].exp_i ? 2'b10 : 2'b01);
      chk($sformatf("v%0d latency", v), dt, vt[v].lat + 2);
      if (vt[v].exp_i) ei_rd = vt[v].rd;
      else ed_rd = vt[v].rd;
      chk($sformatf("v%0d i_rdata", v), bus.i_rdata, ei_rd);
      chk($sformatf("v%0d d_rdata", v), bus.d_rdata, ed_rd);
      if (n_log == n0 + 1) begin
        chk($sformatf("v%0d address", v), log_addr[n0 % 64], vt[v].exp_addr);
        chk($sformatf("v%0d write", v), log_wr[n0 % 64], vt[v].exp_wr);
        chk($sformatf("v%0d strobes", v), log_sc[n0 % 64], vt[v].lat);
        if (vt[v].exp_wr)
          chk($sformatf("v%0d wdata", v), log_wd[n0 % 64], vt[v].wd);
      end else begin
        chk($sformatf("v%0d txn count", v), n_log - n0, 1);
      end
      nxt();
      chk($sformatf("v%0d resp pulse", v), {bus.i_resp, bus.d_resp}, 2'b00);
      drop_all();
      nxt();
      nxt();
    end

    // simultaneous reads, pointer currently prefers the icache
    n0 = n_log;
    mem_lat    = 2;
    rd_pat     = {4{64'hCAFE_F00D_1234_5678}};
    bus.i_read = 1'b1;
    bus.i_addr = 32'h4000_0105;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h5000_0213;
    wait_resp("tie first", gi, gd, dt);
`ifdef CACHE_ARB_RR_EN
    chk("tie first side", {gi, gd}, 2'b10);
    chk("tie first addr", log_addr[n0 % 64], 32'h4000_0100);
`else
    chk("tie first side", {gi, gd}, 2'b01);
    chk("tie first addr", log_addr[n0 % 64], 32'h5000_0200);
`endif
    nxt();
    if (gi) bus.i_read = 1'b0;
    if (gd) bus.d_read = 1'b0;
    wait_resp("tie second", gi, gd, dt);
`ifdef CACHE_ARB_RR_EN
    chk("tie second side", {gi, gd}, 2'b01);
    chk("tie second addr", log_addr[(n0 + 1) % 64], 32'h5000_0200);
`else
    chk("tie second side", {gi, gd}, 2'b10);
    chk("tie second addr", log_addr[(n0 + 1) % 64], 32'h4000_0100);
`endif
    nxt();
    drop_all();
    nxt();

    // lone icache grant so round-robin next prefers the dcache
    bus.i_read = 1'b1;
    wait_resp("pre-starve", gi, gd, dt);
    chk("pre-starve side", {gi, gd}, 2'b10);
    nxt();
    drop_all();
    nxt();

    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    served = -1;
    for (int g = 0; g < 3; g++) begin
      wait_resp("starve", gi, gd, dt);
      nxt();
      if (gi) begin
        served = g;
        bus.i_read = 1'b0;
        break;
      end
    end
`ifdef CACHE_ARB_RR_EN
    chk("starve icache grant index", served, 1);
    wait_resp("starve tail", gi, gd, dt);
    chk("starve tail side", {gi, gd}, 2'b01);
    nxt();
    drop_all();
`else
    chk("starve icache waits", served, -1);
    bus.d_read = 1'b0;
    wait_resp("starve tail", gi, gd, dt);
    chk("starve tail side", {gi, gd}, 2'b10);
    nxt();
    drop_all();
`endif
    nxt();

    // icache holds i_read through its response cycle
    n0 = n_log;
    mem_lat    = 2;
    bus.i_read = 1'b1;
    bus.i_addr = 32'h7000_0000;
    wait_resp("held first", gi, gd, dt);
    chk("held first side", {gi, gd}, 2'b10);
    chk("held no strobe in resp", bus.pmem_read | bus.pmem_write, 1'b0);
    nxt();
    chk("held no strobe in idle", bus.pmem_read | bus.pmem_write, 1'b0);
    wait_resp("held second", gi, gd, dt);
    chk("held second side", {gi, gd}, 2'b10);
    chk("held second latency", dt, 4);
    nxt();
    drop_all();
    nxt();
    chk("held txn count", n_log - n0, 2);

    // reset while the dcache read is in D_BUSY
    mem_lat    = 6;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h2222_2240;
    for (int k = 0; k < 10; k++) begin
      if (bus.pmem_read) break;
      nxt();
    end
    chk("rstmid strobe up", bus.pmem_read, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rstmid resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rstmid address", bus.pmem_address, 0);
    chk("rstmid d_rdata", bus.d_rdata, 0);
    nxt();
    drop_all();
    nxt();
    reset = 1'b1;
    nxt();
    force_resp = 1'b1;
    nxt();
    force_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk($sformatf("late resp ignored %0d", k),
          {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}, 4'b0000);
    end
    chk("late resp d_rdata", bus.d_rdata, 0);
    chk("strobe overlap", both_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
